digit_stroke_classifier: RTL and testbench
==========================================

Name: digit_stroke_classifier

Overview:
- Second-generation stroke-crossing digit classifier; sits beside the VGA overlay path and consumes the same binarised pixel stream (bin_data plus H_Addr/V_Addr).
- Counts foreground strokes crossing one vertical and two horizontal scan lines inside a parametrised ROI, and classifies the digit once per frame.
- Adds the following over the first generation: pixel-valid qualification, a run-length stroke filter, saturating counters, a frame FSM with a one-cycle result strobe, and multi-frame confirmation of a stable result.

Parameters:
- AW, 12, width of H_Addr/V_Addr.
- XMIN, 336, ROI left edge (inclusive).
- XMAX, 464, ROI right edge (exclusive).
- YMIN, 112, ROI top edge (inclusive).
- YMAX, 368, ROI bottom edge (exclusive); also the settle trigger row.
- XL, 400, column of the vertical scan line.
- YL1, 214, row of horizontal scan line 1.
- YL2, 282, row of horizontal scan line 2.
- MIN_RUN, 2, consecutive foreground samples (1..15) required to register one stroke.
- CONFIRM, 3, consecutive identical non-error frames (1..15) before stable_bcd updates.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- pix_valid  in  1  qualifies bin_data/H_Addr/V_Addr this cycle
- bin_data  in  1  binarised pixel, 1 = foreground
- H_Addr  in  AW  pixel column
- V_Addr  in  AW  pixel row
- digit_bcd  out  4  per-frame class code
- digit_valid  out  1  one-cycle strobe, digit_bcd/digit_err/counts valid
- digit_err  out  1  frame pattern unmatched
- stable_bcd  out  4  confirmed class code
- stable_valid  out  1  stable_bcd has been written at least once
- x_cnt  out  2  vertical-line stroke count, saturating
- y1_cnt  out  2  YL1 stroke count, saturating
- y2_cnt  out  2  YL2 stroke count, saturating

Behaviour:
- Reset (rst=1 at a clk edge):
  - state IDLE.
  - digit_bcd=stable_bcd=4'hF.
  - digit_valid=digit_err=stable_valid=0.
  - All counts, run counters and the agree counter cleared.
- Only cycles with pix_valid=1 are sampled; with pix_valid=0, state and counters hold.
- Frame start = accepted pixel at H_Addr=0, V_Addr=0.
- FSM states and transitions:
  - IDLE -> SCAN on frame start; counters and runs cleared at that edge.
  - SCAN -> SETTLE on accepted pixel at V_Addr=YMAX, H_Addr=0.
  - SCAN + frame start (frame aborted before YMAX): clear counters, stay in SCAN, no strobe.
  - SETTLE -> IDLE after one cycle.
- Horizontal lines:
  - On row YLk, sample pixels with XMIN<=H_Addr<XMAX.
  - The run counter counts consecutive foreground pixels and saturates at MIN_RUN.
  - The stroke count increments once, on the sample where the run reaches MIN_RUN.
  - A background sample clears the run; the run is also cleared at H_Addr=XMIN.
- Vertical line:
  - One sample per row at H_Addr=XL, for YMIN<=V_Addr<YMAX.
  - Same run/stroke rule, counted across rows.
- Counts saturate at 3, with no wrap.
- A line position outside the ROI contributes no samples; its count stays 0.
- Classification on the {y1,y2,x} counts, latched in SETTLE:
  - 222->0, 111->1, 113->C (2/3/5), 212->4, 123->6, 112->7, 223->8, 213->9.
  - Any other pattern -> E with digit_err=1.
- Latency:
  - Trigger pixel accepted at edge t; SETTLE during t..t+1.
  - digit_bcd/digit_err/x_cnt/y1_cnt/y2_cnt registered at edge t+1.
  - digit_valid high for exactly the cycle following edge t+1.
- Outputs hold their values until the next settle.
- Confirmation:
  - On each strobe with digit_err=0: if the code equals the previous frame's code, agree++ (saturating at CONFIRM); otherwise agree=1.
  - When agree reaches CONFIRM, stable_bcd is updated (same edge as the strobe) and stable_valid=1.
  - An error frame clears agree.
  - stable_bcd is not changed by error frames or aborted frames.
  - CONFIRM=1: every non-error strobe updates stable_bcd.
- rst mid-frame: everything returns to reset values; no strobe until a full new frame completes.

Test Plan:
- Reset, then a frame with "1" strokes (3-pixel-wide runs once each on YL1, YL2, XL) -> digit_valid one cycle 2 cycles after pixel (0,368); digit_bcd=1, counts 1/1/1, digit_err=0.
- Single-pixel foreground blips on YL1 with MIN_RUN=2 -> not counted; y1_cnt=0, digit_bcd=E, digit_err=1, stable_valid stays 0.
- Three identical "8" frames (223) with CONFIRM=3 -> stable_bcd=8 and stable_valid=1 after the third strobe, not after the second; a 4th frame "0" leaves stable_bcd=8.
- Five separated strokes on YL2 -> y2_cnt saturates at 3, no wrap.
- Frame aborted (V_Addr returns to 0 at row 200), then a full "4" frame -> exactly one strobe, digit_bcd=4, counts 2/1/2.
- rst asserted at row 250 of a "6" frame -> outputs at reset values; next full "6" frame gives digit_bcd=6, agree=1.
- pix_valid deasserted every other cycle during a "9" frame -> digit_bcd=9, identical to the dense-stream result.

Source files
------------

// File: rtl/digit_stroke_classifier.sv
// Stroke-crossing digit classifier: counts foreground runs on two horizontal and one
// vertical scan line inside an ROI, classifies once per frame and confirms stable results.
module digit_stroke_classifier #(
  parameter int AW      = 12,
  parameter int XMIN    = 336,
  parameter int XMAX    = 464,
  parameter int YMIN    = 112,
  parameter int YMAX    = 368,
  parameter int XL      = 400,
  parameter int YL1     = 214,
  parameter int YL2     = 282,
  parameter int MIN_RUN = 2,
  parameter int CONFIRM = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic          bin_data,
  input  logic [AW-1:0] H_Addr,
  input  logic [AW-1:0] V_Addr,
  output logic [3:0]    digit_bcd,
  output logic          digit_valid,
  output logic          digit_err,
  output logic [3:0]    stable_bcd,
  output logic          stable_valid,
  output logic [1:0]    x_cnt,
  output logic [1:0]    y1_cnt,
  output logic [1:0]    y2_cnt
);

  localparam logic [AW-1:0] XMIN_A = AW'(XMIN);
  localparam logic [AW-1:0] XMAX_A = AW'(XMAX);
  localparam logic [AW-1:0] YMIN_A = AW'(YMIN);
  localparam logic [AW-1:0] YMAX_A = AW'(YMAX);
  localparam logic [AW-1:0] XL_A   = AW'(XL);
  localparam logic [AW-1:0] YL1_A  = AW'(YL1);
  localparam logic [AW-1:0] YL2_A  = AW'(YL2);
  localparam logic [3:0]    MR     = 4'(MIN_RUN);
  localparam logic [3:0]    MR_M1  = 4'(MIN_RUN - 1);
  localparam logic [3:0]    CF     = 4'(CONFIRM);
  localparam logic          Y1_ON  = (YL1 >= YMIN) && (YL1 < YMAX);
  localparam logic          Y2_ON  = (YL2 >= YMIN) && (YL2 < YMAX);
  localparam logic          X_ON   = (XL >= XMIN) && (XL < XMAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] run_y1_q, run_y1_d, run_y2_q, run_y2_d, run_x_q, run_x_d;
  logic [1:0] cnt_y1_q, cnt_y1_d, cnt_y2_q, cnt_y2_d, cnt_x_q, cnt_x_d;
  logic [3:0] agree_q, agree_d, prev_q, prev_d;
  logic [3:0] digit_bcd_q, digit_bcd_d, stable_bcd_q, stable_bcd_d;
  logic       digit_valid_q, digit_valid_d, digit_err_q, digit_err_d;
  logic       stable_valid_q, stable_valid_d;
  logic [1:0] out_x_q, out_x_d, out_y1_q, out_y1_d, out_y2_q, out_y2_d;

  logic       frame_start_s, trigger_s, in_x_s, hit_y1_s, hit_y2_s, hit_x_s;
  logic [3:0] base_y1_s, base_y2_s, code_s;

  function automatic logic [3:0] run_step(input logic [3:0] base, input logic fg);
    logic [3:0] r;
    if (!fg) r = 4'd0;
    else if (base >= MR) r = MR;
    else r = base + 4'd1;
    return r;
  endfunction

  // A stroke is registered only on the sample where the run first reaches MIN_RUN.
  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic [3:0] base,
                                          input logic fg);
    logic [1:0] r;
    r = cnt;
    if (fg && (base == MR_M1) && (cnt != 2'd3)) r = cnt + 2'd1;
    else r = cnt;
    return r;
  endfunction

  function automatic logic [3:0] classify(input logic [5:0] key);
    logic [3:0] c;
    case (key)
      {2'd2, 2'd2, 2'd2}: c = 4'h0;
      {2'd1, 2'd1, 2'd1}: c = 4'h1;
      {2'd1, 2'd1, 2'd3}: c = 4'hC;
      {2'd2, 2'd1, 2'd2}: c = 4'h4;
      {2'd1, 2'd2, 2'd3}: c = 4'h6;
      {2'd1, 2'd1, 2'd2}: c = 4'h7;
      {2'd2, 2'd2, 2'd3}: c = 4'h8;
      {2'd2, 2'd1, 2'd3}: c = 4'h9;
      default:            c = 4'hE;
    endcase
    return c;
  endfunction

  assign frame_start_s = pix_valid && (H_Addr == '0) && (V_Addr == '0);
  assign trigger_s     = pix_valid && (H_Addr == '0) && (V_Addr == YMAX_A);
  assign in_x_s        = (H_Addr >= XMIN_A) && (H_Addr < XMAX_A);
  assign hit_y1_s      = Y1_ON && pix_valid && (V_Addr == YL1_A) && in_x_s;
  assign hit_y2_s      = Y2_ON && pix_valid && (V_Addr == YL2_A) && in_x_s;
  assign hit_x_s       = X_ON && pix_valid && (H_Addr == XL_A) &&
                         (V_Addr >= YMIN_A) && (V_Addr < YMAX_A);
  assign base_y1_s     = (H_Addr == XMIN_A) ? 4'd0 : run_y1_q;
  assign base_y2_s     = (H_Addr == XMIN_A) ? 4'd0 : run_y2_q;
  assign code_s        = classify({cnt_y1_q, cnt_y2_q, cnt_x_q});

  // Frame FSM next state, stroke counting, per-frame latch and confirmation.
  always_comb begin
    state_d        = state_q;
    run_y1_d       = run_y1_q;
    run_y2_d       = run_y2_q;
    run_x_d        = run_x_q;
    cnt_y1_d       = cnt_y1_q;
    cnt_y2_d       = cnt_y2_q;
    cnt_x_d        = cnt_x_q;
    agree_d        = agree_q;
    prev_d         = prev_q;
    digit_bcd_d    = digit_bcd_q;
    digit_err_d    = digit_err_q;
    digit_valid_d  = 1'b0;
    stable_bcd_d   = stable_bcd_q;
    stable_valid_d = stable_valid_q;
    out_x_d        = out_x_q;
    out_y1_d       = out_y1_q;
    out_y2_d       = out_y2_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start_s) begin
          state_d  = S_SCAN;
          run_y1_d = 4'd0; run_y2_d = 4'd0; run_x_d = 4'd0;
          cnt_y1_d = 2'd0; cnt_y2_d = 2'd0; cnt_x_d = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (frame_start_s) begin
          run_y1_d = 4'd0; run_y2_d = 4'd0; run_x_d = 4'd0;
          cnt_y1_d = 2'd0; cnt_y2_d = 2'd0; cnt_x_d = 2'd0;
        end else if (trigger_s) begin
          state_d = S_SETTLE;
        end else begin
          if (hit_y1_s) begin
            run_y1_d = run_step(base_y1_s, bin_data);
            cnt_y1_d = cnt_step(cnt_y1_q, base_y1_s, bin_data);
          end
          if (hit_y2_s) begin
            run_y2_d = run_step(base_y2_s, bin_data);
            cnt_y2_d = cnt_step(cnt_y2_q, base_y2_s, bin_data);
          end
          if (hit_x_s) begin
            run_x_d = run_step(run_x_q, bin_data);
            cnt_x_d = cnt_step(cnt_x_q, run_x_q, bin_data);
          end
        end
      end
      S_SETTLE: begin
        state_d       = S_IDLE;
        digit_valid_d = 1'b1;
        digit_bcd_d   = code_s;
        out_x_d       = cnt_x_q;
        out_y1_d      = cnt_y1_q;
        out_y2_d      = cnt_y2_q;
        if (code_s == 4'hE) begin
          digit_err_d = 1'b1;
          agree_d     = 4'd0;
        end else begin
          digit_err_d = 1'b0;
          prev_d      = code_s;
          if ((agree_q != 4'd0) && (code_s == prev_q)) begin
            agree_d = (agree_q >= CF) ? CF : agree_q + 4'd1;
          end else begin
            agree_d = 4'd1;
          end
          if (agree_d == CF) begin
            stable_bcd_d   = code_s;
            stable_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      run_y1_q       <= 4'd0;
      run_y2_q       <= 4'd0;
      run_x_q        <= 4'd0;
      cnt_y1_q       <= 2'd0;
      cnt_y2_q       <= 2'd0;
      cnt_x_q        <= 2'd0;
      agree_q        <= 4'd0;
      prev_q         <= 4'hF;
      digit_bcd_q    <= 4'hF;
      digit_err_q    <= 1'b0;
      digit_valid_q  <= 1'b0;
      stable_bcd_q   <= 4'hF;
      stable_valid_q <= 1'b0;
      out_x_q        <= 2'd0;
      out_y1_q       <= 2'd0;
      out_y2_q       <= 2'd0;
    end else begin
      state_q        <= state_d;
      run_y1_q       <= run_y1_d;
      run_y2_q       <= run_y2_d;
      run_x_q        <= run_x_d;
      cnt_y1_q       <= cnt_y1_d;
      cnt_y2_q       <= cnt_y2_d;
      cnt_x_q        <= cnt_x_d;
      agree_q        <= agree_d;
      prev_q         <= prev_d;
      digit_bcd_q    <= digit_bcd_d;
      digit_err_q    <= digit_err_d;
      digit_valid_q  <= digit_valid_d;
      stable_bcd_q   <= stable_bcd_d;
      stable_valid_q <= stable_valid_d;
      out_x_q        <= out_x_d;
      out_y1_q       <= out_y1_d;
      out_y2_q       <= out_y2_d;
    end
  end

  assign digit_bcd    = digit_bcd_q;
  assign digit_valid  = digit_valid_q;
  assign digit_err    = digit_err_q;
  assign stable_bcd   = stable_bcd_q;
  assign stable_valid = stable_valid_q;
  assign x_cnt        = out_x_q;
  assign y1_cnt       = out_y1_q;
  assign y2_cnt       = out_y2_q;

endmodule

// File: tb/tb_digit_stroke_classifier.sv
// Directed + randomized bench for digit_stroke_classifier with a run-counting reference model.
module tb_digit_stroke_classifier;

  localparam int AW = 12, XMIN = 336, XMAX = 464, YMIN = 112, YMAX = 368;
  localparam int XL = 400, YL1 = 214, YL2 = 282, MIN_RUN = 2, CONFIRM = 3;
  localparam int RLEN = XMAX - XMIN, CLEN = YMAX - YMIN;

  logic          clk = 1'b0;
  logic          rst, pix_valid, bin_data;
  logic [AW-1:0] H_Addr, V_Addr;
  logic [3:0]    digit_bcd, stable_bcd;
  logic          digit_valid, digit_err, stable_valid;
  logic [1:0]    x_cnt, y1_cnt, y2_cnt;

  digit_stroke_classifier dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .bin_data(bin_data),
    .H_Addr(H_Addr), .V_Addr(V_Addr), .digit_bcd(digit_bcd), .digit_valid(digit_valid),
    .digit_err(digit_err), .stable_bcd(stable_bcd), .stable_valid(stable_valid),
    .x_cnt(x_cnt), .y1_cnt(y1_cnt), .y2_cnt(y2_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, strobes = 0;
  bit [255:0] r1, r2, cv;
  bit sparse = 1'b0;
  int exp_stable = 15, exp_sv = 0;
  int hist[$];

  always @(negedge clk) if (digit_valid === 1'b1) strobes++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_runs(input bit [255:0] line, input int len);
    int runs = 0, cur = 0;
    for (int i = 0; i < len; i++) begin
      if (line[i]) cur++;
      else begin
        if (cur >= MIN_RUN) runs++;
        cur = 0;
      end
    end
    if (cur >= MIN_RUN) runs++;
    return (runs > 3) ? 3 : runs;
  endfunction

  function automatic int classify(input int y1, input int y2, input int x);
    case (100 * y1 + 10 * y2 + x)
      222: return 0;  111: return 1;  113: return 12; 212: return 4;
      123: return 6;  112: return 7;  223: return 8;  213: return 9;
      default: return 14;
    endcase
  endfunction

  // n strokes (width MIN_RUN..MIN_RUN+2) and nb single-pixel blips, never covering f0/f1
  function automatic bit [255:0] gen_line(input int n, input int nb, input int f0, input int f1);
    bit [255:0] line = '0;
    int pos = $urandom_range(0, 3);
    int w;
    for (int s = 0; s < n || s < nb; s++) begin
      if (s < n) begin
        w = MIN_RUN + $urandom_range(0, 2);
        while ((pos <= f0 && pos + w > f0) || (pos <= f1 && pos + w > f1)) pos++;
        for (int k = 0; k < w; k++) line[pos + k] = 1'b1;
        pos += w + 1 + $urandom_range(0, 3);
      end
      if (s < nb) begin
        while (pos == f0 || pos == f1) pos++;
        line[pos] = 1'b1;
        pos += 2 + $urandom_range(0, 2);
      end
    end
    return line;
  endfunction

  task automatic set_digit(input int y1, input int y2, input int x, input int nb);
    r1 = gen_line(y1, nb, XL - XMIN, XL - XMIN);
    r2 = gen_line(y2, nb, XL - XMIN, XL - XMIN);
    cv = gen_line(x, nb, YL1 - YMIN, YL2 - YMIN);
  endtask

  task automatic pix(input int v, input int h, input bit d);
    if (sparse) begin
      @(negedge clk);
      pix_valid = 1'b0;
      H_Addr    = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      V_Addr    = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      bin_data  = 1'($urandom);
    end
    @(negedge clk);
    pix_valid = 1'b1;
    V_Addr    = AW'(v);
    H_Addr    = AW'(h);
    bin_data  = d;
  endtask

  task automatic drive_frame(input int stop_row);
    bit d;
    pix(0, 0, 1'b0);
    pix(YMIN - 1, XL, 1'($urandom));
    for (int v = YMIN; v < stop_row && v < YMAX; v++) begin
      if (v == YL1 || v == YL2) begin
        for (int h = XMIN - 4; h < XMAX + 4; h++) begin
          if (h < XMIN || h >= XMAX) d = 1'($urandom);
          else d = (v == YL1) ? r1[h - XMIN] : r2[h - XMIN];
          pix(v, h, d);
        end
      end else begin
        pix(v, XL, cv[v - YMIN]);
      end
    end
  endtask

  task automatic finish_frame(input string tag);
    int ey1, ey2, ex, code, n;
    bit same;
    ey1  = count_runs(r1, RLEN);
    ey2  = count_runs(r2, RLEN);
    ex   = count_runs(cv, CLEN);
    code = classify(ey1, ey2, ex);
    hist.push_back(code);
    n = hist.size();
    if (n >= CONFIRM) begin
      same = (hist[n-1] != 14);
      for (int i = 2; i <= CONFIRM; i++) if (hist[n-i] != hist[n-1]) same = 1'b0;
      if (same) begin
        exp_stable = hist[n-1];
        exp_sv     = 1;
      end
    end
    pix(YMAX, 0, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".dv_early"}, 32'(digit_valid), 0);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".dv"}, 32'(digit_valid), 1);
    chk({tag, ".bcd"}, 32'(digit_bcd), code);
    chk({tag, ".err"}, 32'(digit_err), (code == 14) ? 1 : 0);
    chk({tag, ".y1"}, 32'(y1_cnt), ey1);
    chk({tag, ".y2"}, 32'(y2_cnt), ey2);
    chk({tag, ".x"}, 32'(x_cnt), ex);
    chk({tag, ".stable"}, 32'(stable_bcd), exp_stable);
    chk({tag, ".sv"}, 32'(stable_valid), exp_sv);
    @(posedge clk); #1;
    chk({tag, ".dv_off"}, 32'(digit_valid), 0);
    chk({tag, ".bcd_hold"}, 32'(digit_bcd), code);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".dv"}, 32'(digit_valid), 0);
    chk({tag, ".bcd"}, 32'(digit_bcd), 15);
    chk({tag, ".err"}, 32'(digit_err), 0);
    chk({tag, ".stable"}, 32'(stable_bcd), 15);
    chk({tag, ".sv"}, 32'(stable_valid), 0);
    chk({tag, ".cnts"}, 32'({y1_cnt, y2_cnt, x_cnt}), 0);
  endtask

  initial begin
    int pats[8] = '{222, 111, 113, 212, 123, 112, 223, 213};
    int key, s0;
    rst = 1'b1; pix_valid = 1'b0; bin_data = 1'b0; H_Addr = '0; V_Addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check_reset_state("reset");

    // "1": one 3-wide stroke per line
    r1 = '0; r2 = '0; cv = '0;
    for (int k = 0; k < 3; k++) begin
      r1[10 + k] = 1'b1; r2[20 + k] = 1'b1; cv[30 + k] = 1'b1;
    end
    drive_frame(YMAX); finish_frame("one");

    // single-pixel blips on YL1 only
    r1 = gen_line(0, 6, XL - XMIN, XL - XMIN); r2 = '0; cv = '0;
    drive_frame(YMAX); finish_frame("blips");

    for (int f = 0; f < 3; f++) begin
      set_digit(2, 2, 3, $urandom_range(0, 2));
      drive_frame(YMAX); finish_frame($sformatf("eight%0d", f));
    end
    chk("eight.stable_final", 32'(stable_bcd), 8);
    set_digit(2, 2, 2, 0); drive_frame(YMAX); finish_frame("zero_after8");

    set_digit(1, 5, 1, 0); drive_frame(YMAX); finish_frame("y2_sat");

    // aborted frame followed by a full "4"
    set_digit(2, 1, 2, 1);
    s0 = strobes;
    drive_frame(200); drive_frame(YMAX); finish_frame("abort4");
    chk("abort4.strobes", 32'(strobes - s0), 1);

    // reset in the middle of a "6" frame
    set_digit(1, 2, 3, 1);
    drive_frame(250);
    @(negedge clk); rst = 1'b1; pix_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    hist.delete(); exp_stable = 15; exp_sv = 0;
    check_reset_state("midrst");
    drive_frame(YMAX); finish_frame("six_after_rst");

    // "9" dense, then the identical frame with gapped pix_valid
    set_digit(2, 1, 3, 2);
    drive_frame(YMAX); finish_frame("nine_dense");
    sparse = 1'b1;
    drive_frame(YMAX); finish_frame("nine_sparse");
    sparse = 1'b0;

    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 3) == 0) key = 100 * $urandom_range(0, 4) + 10 * $urandom_range(0, 4) + $urandom_range(0, 4);
      else if (f == 0 || $urandom_range(0, 1) == 0) key = pats[$urandom_range(0, 7)];
      sparse = ($urandom_range(0, 2) == 0);
      set_digit(key / 100, (key / 10) % 10, key % 10, $urandom_range(0, 3));
      drive_frame(YMAX); finish_frame($sformatf("rand%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
